seg_display_mux: RTL

- Parametrised multiplexed seven-segment driver for N_DIGITS common-anode digits.
- Accepts a DATA_W-bit value and shows it in hex, or in decimal via an on-block sequential double-dabble converter.
- Adds leading-zero blanking, per-digit decimal points, a start/busy load handshake and decimal overflow flagging.
- Sits between CPU statistics/debug registers and the board's SEG/AN pins.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_display_mux_bcd_seq_converter.sv | 69 ++++++
 rtl/seg_display_mux.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display mux.
// Segment codes are active low: bit7 = dp, bits6..0 = g..a.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hA7,
    8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Decimal digits needed for a width-bit unsigned value.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg_display_mux_bcd_seq_converter.sv
// Sequential double-dabble binary to BCD converter.
// One shift per clock; done pulses for one cycle in DONE.
module bcd_seq_converter
  import seg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [DATA_W-1:0]                bin,
  output logic                             busy,
  output logic                             done,
  output logic [4*bcd_digits(DATA_W)-1:0]  bcd
);

  localparam int BD = bcd_digits(DATA_W);
  localparam int BW = 4 * BD;
  localparam int CW = $clog2(DATA_W + 1);

  conv_state_t       state;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;

  // Add 3 to every nibble of 5 or more before the shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < BD; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Converter FSM: capture, shift DATA_W times, one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= bin;
            acc   <= '0;
            cnt   <= CW'(DATA_W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, sr} <= {adj, sr} << 1;
          cnt       <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = acc;

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver, hex or decimal display,
// with leading-zero blanking, decimal points and overflow dash.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                mode,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_in,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int DW4 = 4 * N_DIGITS;
  localparam int BW  = 4 * bcd_digits(DATA_W);
  localparam int HW  = (DATA_W > DW4) ? DATA_W : DW4;
  localparam int DWW = (BW > DW4) ? BW : DW4;
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DW4-1:0] disp;
  logic           dec_shown;
  logic [RCW-1:0] rcnt;
  logic [IW-1:0]  idx;
  logic           conv_busy;
  logic           conv_done;
  logic [BW-1:0]  bcd;
  logic           accept;
  logic [HW-1:0]  hex_ext;
  logic [DWW-1:0] bcd_ext;
  logic [3:0]     nib;
  logic [DW4-1:0] upper;
  logic           lz;
  logic [7:0]     code;

  assign accept  = load & ~conv_busy;
  assign hex_ext = HW'(data_in);
  assign bcd_ext = DWW'(bcd);
  assign busy    = conv_busy;

  bcd_seq_converter #(
    .DATA_W (DATA_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & mode),
    .bin   (data_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Display register: hex loads directly, decimal on converter done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      overflow  <= 1'b0;
      dec_shown <= 1'b0;
    end else if (accept && !mode) begin
      disp      <= hex_ext[DW4-1:0];
      overflow  <= |(hex_ext >> DW4);
      dec_shown <= 1'b0;
    end else if (conv_done) begin
      disp      <= bcd_ext[DW4-1:0];
      overflow  <= |(bcd_ext >> DW4);
      dec_shown <= 1'b1;
    end
  end

  // Refresh timer: advance the digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RCW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Segment pattern for the current slot.
  always_comb begin
    nib   = disp[4*idx +: 4];
    upper = disp >> (4 * idx);
    lz    = blank_lz && (idx != '0) && (upper == '0);
    unique case (1'b1)
      overflow && dec_shown: code = SEG_DASH;
      lz:                    code = SEG_BLANK;
      default:               code = SEG_HEX[nib];
    endcase
    if (dp_in[idx])
      code[7] = 1'b0;
  end

  // seg and an registered together so they always match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= code;
      an  <= ~(N_DIGITS'(1) << idx);
    end
  end

endmodule
